// File: rtl/sum_pkg.sv
// Shared constants and helpers for the sum_avg_pipe reduction pipeline.
package sum_pkg;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    // Data width after adder-tree level k; each level grows by one carry bit.
    function automatic int unsigned w_stage(int unsigned w, int unsigned k);
        return w + k;
    endfunction

endpackage

// File: rtl/sum_avg_pipe_if.sv
// Sample/result bundle for sum_avg_pipe; the slave side is the pipeline.
interface sum_avg_pipe_if #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 4
);
    logic                      in_val;
    logic [2**N-1:0][W-1:0]    in;
    logic                      mode;
    logic                      flush;
    logic                      out_val;
    logic [W+N-1:0]            res;
    logic                      out_mode;

    modport master (
        output in_val, in, mode, flush,
        input  out_val, res, out_mode
    );

    modport slave (
        input  in_val, in, mode, flush,
        output out_val, res, out_mode
    );
endinterface

// File: rtl/sum_stage.sv
// One registered pairwise-add level of the adder tree; carries valid and mode alongside data.
module sum_stage #(
    parameter int unsigned W_IN   = 8,
    parameter int unsigned PAIRS  = 1,
    parameter int unsigned SIGNED = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           kill,
    input  logic                           in_val,
    input  logic                           in_mode,
    input  logic [2*PAIRS-1:0][W_IN-1:0]   in_data,
    output logic                           out_val,
    output logic                           out_mode,
    output logic [PAIRS-1:0][W_IN:0]       out_data
);

    function automatic logic [W_IN:0] ext(logic [W_IN-1:0] x);
        return {(SIGNED != 0) && x[W_IN-1], x};
    endfunction

    logic [PAIRS-1:0][W_IN:0] sum_d;
    logic                     adv;

    assign adv = in_val & ~kill;

    always_comb begin
        sum_d = '0;
        for (int p = 0; p < int'(PAIRS); p++) begin
            sum_d[p] = ext(in_data[2*p]) + ext(in_data[2*p+1]);
        end
    end

    // Data and mode only move with a valid sample so idle stages stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val  <= 1'b0;
            out_mode <= 1'b0;
            out_data <= '0;
        end else begin
            out_val <= adv;
            if (adv) begin
                out_mode <= in_mode;
                out_data <= sum_d;
            end
        end
    end

endmodule

// File: rtl/sum_avg_pipe.sv
// Pipelined sum/average of 2**N samples: N adder levels plus a registered mode stage.
// Define SUM_AVG_PIPE_ROUND_EN to round averages half up instead of truncating.
module sum_avg_pipe
    import sum_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned N      = 4,
    parameter int unsigned SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    sum_avg_pipe_if.slave   bus
);

    for (genvar k = 0; k < int'(N); k++) begin : g_stage
        localparam int unsigned Pairs = 2 ** (N - 1 - k);

        logic [2*Pairs-1:0][w_stage(W, k)-1:0] d_in;
        logic [Pairs-1:0][w_stage(W, k+1)-1:0] d_out;
        logic                                  v_in, m_in, kill;
        logic                                  v_out, m_out;

        // A flush never kills the sample entering the first level.
        if (k == 0) begin : g_first
            assign d_in = bus.in;
            assign v_in = bus.in_val;
            assign m_in = bus.mode;
            assign kill = 1'b0;
        end else begin : g_next
            assign d_in = g_stage[k-1].d_out;
            assign v_in = g_stage[k-1].v_out;
            assign m_in = g_stage[k-1].m_out;
            assign kill = bus.flush;
        end

        sum_stage #(
            .W_IN   (w_stage(W, k)),
            .PAIRS  (Pairs),
            .SIGNED (SIGNED)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .kill     (kill),
            .in_val   (v_in),
            .in_mode  (m_in),
            .in_data  (d_in),
            .out_val  (v_out),
            .out_mode (m_out),
            .out_data (d_out)
        );
    end

    logic [W+N-1:0] sum_w, res_d, res_q;
    logic [W+N:0]   sum_x, rnd_x, avg_x;
    logic           v_last, m_last, adv;
    logic           out_val_q, out_mode_q;

`ifdef SUM_AVG_PIPE_ROUND_EN
    localparam logic [W+N:0] Half = (W+N+1)'(2 ** (N - 1));
`endif

    assign sum_w  = g_stage[N-1].d_out[0];
    assign v_last = g_stage[N-1].v_out;
    assign m_last = g_stage[N-1].m_out;
    assign adv    = v_last & ~bus.flush;

    // One spare bit keeps the rounding add from overflowing.
    always_comb begin
        sum_x = {(SIGNED != 0) && sum_w[W+N-1], sum_w};
`ifdef SUM_AVG_PIPE_ROUND_EN
        rnd_x = sum_x + Half;
`else
        rnd_x = sum_x;
`endif
        if (SIGNED != 0) begin
            avg_x = $signed(rnd_x) >>> N;
        end else begin
            avg_x = rnd_x >> N;
        end
        res_d = (m_last == MODE_AVG) ? avg_x[W+N-1:0] : sum_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_q  <= 1'b0;
            out_mode_q <= 1'b0;
            res_q      <= '0;
        end else begin
            out_val_q <= adv;
            if (adv) begin
                out_mode_q <= m_last;
                res_q      <= res_d;
            end
        end
    end

    assign bus.out_val  = out_val_q;
    assign bus.res      = res_q;
    assign bus.out_mode = out_mode_q;

endmodule

// File: tb/tb_sum_avg_pipe.sv
// Self-checking bench for sum_avg_pipe: unsigned and signed instances (W=8, N=2) driven in lockstep.
module tb_sum_avg_pipe;

    localparam int unsigned W = 8;
    localparam int unsigned N = 2;
    localparam int unsigned K = 2 ** N;
`ifdef SUM_AVG_PIPE_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef logic [K-1:0][W-1:0] vec_in_t;
    typedef logic [W+N-1:0]      res_t;

    typedef struct {
        vec_in_t d;
        bit      m;
        res_t    eu;
        res_t    es;
    } vec_t;

    typedef struct {
        int   due;
        res_t ru;
        res_t rs;
        bit   m;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    vec_t tab[6];

    always #5 clk = ~clk;

    sum_avg_pipe_if #(.W(W), .N(N)) bus_u ();
    sum_avg_pipe_if #(.W(W), .N(N)) bus_s ();

    sum_avg_pipe #(.W(W), .N(N), .SIGNED(0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));
    sum_avg_pipe #(.W(W), .N(N), .SIGNED(1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    function automatic int floor_div(int a, int d);
        int r;
        r = a / d;
        if ((a % d != 0) && (a < 0)) r = r - 1;
        return r;
    endfunction

    // Reference: plain integer sum, then floor division for the average.
    function automatic res_t ref_res(vec_in_t d, bit m, bit sgn);
        int s;
        int r;
        s = 0;
        for (int j = 0; j < int'(K); j++) begin
            if (sgn) s += int'($signed(d[j]));
            else     s += int'(d[j]);
        end
        if (!m)       r = s;
        else if (RND) r = floor_div(s + int'(K) / 2, int'(K));
        else          r = floor_div(s, int'(K));
        return res_t'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        bool_t: begin
            bit   want;
            exp_t e;
            want = (q.size() > 0) && (q[0].due == cyc);
            chk("out_val_u", 32'(bus_u.out_val), 32'(want));
            chk("out_val_s", 32'(bus_s.out_val), 32'(want));
            if (want) begin
                e = q.pop_front();
                chk("res_u", 32'(bus_u.res), 32'(e.ru));
                chk("res_s", 32'(bus_s.res), 32'(e.rs));
                chk("out_mode_u", 32'(bus_u.out_mode), 32'(e.m));
                chk("out_mode_s", 32'(bus_s.out_mode), 32'(e.m));
            end
        end
    endtask

    // Drive one cycle, update the model at the edge, then sample #1 later.
    task automatic step(input bit v, input bit m, input bit f, input vec_in_t d,
                        input bit use_tab, input res_t tu, input res_t ts);
        exp_t e;
        bus_u.in_val = v;  bus_s.in_val = v;
        bus_u.mode   = m;  bus_s.mode   = m;
        bus_u.flush  = f;  bus_s.flush  = f;
        bus_u.in     = d;  bus_s.in     = d;
        @(posedge clk);
        cyc++;
        if (f) q.delete();
        if (v) begin
            e.due = cyc + int'(N);
            e.ru  = use_tab ? tu : ref_res(d, m, 1'b0);
            e.rs  = use_tab ? ts : ref_res(d, m, 1'b1);
            e.m   = m;
            q.push_back(e);
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic issue(input bit m, input bit f, input vec_in_t d);
        step(1'b1, m, f, d, 1'b0, '0, '0);
    endtask

    initial begin
        vec_in_t d;

        tab[0] = '{d: {8'd40, 8'd30, 8'd20, 8'd10}, m: 1'b0, eu: 10'd100, es: 10'd100};
        tab[1] = '{d: {8'd255, 8'd255, 8'd255, 8'd255}, m: 1'b1, eu: 10'd255, es: 10'h3FF};
        tab[2] = '{d: {8'd2, 8'd1, 8'd1, 8'd1}, m: 1'b1, eu: 10'd1, es: 10'd1};
        tab[3] = '{d: {8'd2, 8'd2, 8'd1, 8'd1}, m: 1'b1,
                   eu: RND ? 10'd2 : 10'd1, es: RND ? 10'd2 : 10'd1};
        tab[4] = '{d: {8'd254, 8'd255, 8'd255, 8'd255}, m: 1'b1,
                   eu: RND ? 10'd255 : 10'd254, es: RND ? 10'h3FF : 10'h3FE};
        tab[5] = '{d: {8'd254, 8'd255, 8'd255, 8'd255}, m: 1'b0, eu: 10'd1019, es: 10'h3FB};

        bus_u.in_val = 1'b0; bus_u.mode = 1'b0; bus_u.flush = 1'b0; bus_u.in = '0;
        bus_s.in_val = 1'b0; bus_s.mode = 1'b0; bus_s.flush = 1'b0; bus_s.in = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_val_u", 32'(bus_u.out_val), 32'd0);
        chk("rst_res_u", 32'(bus_u.res), 32'd0);
        chk("rst_out_mode_u", 32'(bus_u.out_mode), 32'd0);
        chk("rst_out_val_s", 32'(bus_s.out_val), 32'd0);
        chk("rst_res_s", 32'(bus_s.res), 32'd0);
        chk("rst_out_mode_s", 32'(bus_s.out_mode), 32'd0);

        // First input lands on the very first edge after release.
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tab[i].m, 1'b0, tab[i].d, 1'b1, tab[i].eu, tab[i].es);
            idle(int'(N) + 2);
        end

        // Back-to-back ramp with alternating mode.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < int'(K); j++) d[j] = 8'(i * 37 + j * 61 + 100);
            issue(i[0], 1'b0, d);
        end
        idle(int'(N) + 2);

        // Flush together with a third input: only the third survives.
        issue(1'b0, 1'b0, {8'd1, 8'd2, 8'd3, 8'd4});
        issue(1'b1, 1'b0, {8'd5, 8'd6, 8'd7, 8'd8});
        issue(1'b0, 1'b1, {8'd200, 8'd100, 8'd50, 8'd9});
        idle(int'(N) + 2);

        // Bare flush with two results in flight.
        issue(1'b1, 1'b0, {8'd128, 8'd3, 8'd77, 8'd200});
        issue(1'b0, 1'b0, {8'd9, 8'd8, 8'd7, 8'd6});
        step(1'b0, 1'b0, 1'b1, '0, 1'b0, '0, '0);
        idle(int'(N) + 2);

        // Async reset mid-cycle with two results in flight.
        issue(1'b0, 1'b0, {8'd11, 8'd22, 8'd33, 8'd44});
        issue(1'b1, 1'b0, {8'd99, 8'd88, 8'd77, 8'd66});
        bus_u.in_val = 1'b0; bus_s.in_val = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("arst_out_val_u", 32'(bus_u.out_val), 32'd0);
        chk("arst_res_u", 32'(bus_u.res), 32'd0);
        chk("arst_out_val_s", 32'(bus_s.out_val), 32'd0);
        chk("arst_res_s", 32'(bus_s.res), 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        idle(int'(N) + 3);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < int'(K); j++) d[j] = 8'($urandom_range(0, 255));
            step(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 19) == 0),
                 d, 1'b0, '0, '0);
        end
        idle(int'(N) + 3);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_avg_pipe.md
SUM_AVG_PIPE -- requirements
Module: sum_avg_pipe

Interface
REQ-001 Parameter W, default 8: bit width of each input sample.
REQ-002 Parameter N, default 4: the block reduces 2**N samples; legal range 1..6.
REQ-003 Parameter SIGNED, default 0: 0 treats samples as unsigned, 1 as two's complement.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_val  input  1  qualifies in and mode in the current cycle.
REQ-007 in  input  [2**N-1:0][W-1:0]  packed sample vector.
REQ-008 mode  input  1  0 = sum, 1 = average; sampled with in_val.
REQ-009 flush  input  1  synchronous kill of all in-flight results.
REQ-010 out_val  output  1  qualifies res for exactly one cycle per accepted input.
REQ-011 res  output  [W+N-1:0]  sum, or average extended to W+N bits.
REQ-012 out_mode  output  1  mode value that travelled with res.

Function
REQ-013 The adder tree SHALL have N registered stages; stage k adds pairs and widens by 1 bit (W+k bits).
REQ-014 A final registered stage SHALL apply the mode; latency from in_val to out_val SHALL be exactly N+1 cycles.
REQ-015 The pipeline SHALL accept one input every cycle, with no stalls and no backpressure.
REQ-016 Each stage SHALL carry a valid bit and a mode bit aligned with its data.
REQ-017 Stages whose valid bit is 0 SHALL hold their data registers (no toggling).
REQ-018 Sum mode SHALL output the exact sum with no overflow, sign-extended if SIGNED=1, else zero-extended.
REQ-019 Average mode SHALL output sum>>N; the shift is arithmetic if SIGNED=1, else logical. The W-bit result is extended to W+N bits as in REQ-018.
REQ-020 With flush=1, all stage valid bits SHALL clear at the next edge. out_val SHALL be 0 for the following N+1 cycles unless new inputs arrive.
REQ-021 When in_val=1 and flush=1 in the same cycle, the new input SHALL be accepted and the older in-flight results discarded.
REQ-022 Back-to-back inputs with alternating mode SHALL produce results with the correct per-sample mode.

Reset
REQ-023 While rst_n=0: out_val=0, res=0, out_mode=0, and all stage valid, data and mode registers are 0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight results; no out_val SHALL appear for inputs accepted before reset.
REQ-025 The first input after reset release SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro SUM_AVG_PIPE_ROUND_EN defined: average mode SHALL compute (sum + 2**(N-1))>>N, i.e. round half up (toward +inf for signed). Computation uses a W+N+1 bit intermediate so the add cannot overflow.
REQ-027 Macro undefined: average mode SHALL truncate per REQ-019. Sum mode is identical in both builds.

Structure
REQ-028 Package sum_pkg SHALL hold the mode encoding constants (MODE_SUM=0, MODE_AVG=1) and a stage-width function w_stage(W,k)=W+k.
REQ-029 One sub-module, sum_stage, SHALL implement one registered pairwise-add level (parameters W_IN, PAIRS, SIGNED; carries valid/mode). It is instantiated N times via generate.
REQ-030 The top level SHALL contain only the stage chain, the mode/rounding output stage and flush/valid control.

Verification (W=8, N=2 unless noted)
REQ-031 in={10,20,30,40}, mode=0, single in_val pulse -> out_val 3 cycles later, res=100, out_mode=0.
REQ-032 in={255,255,255,255}, mode=1, unsigned -> res=255. With in={1,1,1,2}: res=1 in both builds (sum 5; truncation gives 1, rounding (5+2)>>2 gives 1). With in={1,1,2,2}: sum 6, res=2 with ROUND_EN, 1 without.
REQ-033 SIGNED=1, in={-1,-1,-1,-2}, mode=1 -> sum -5; res=-2 truncated, -1 with ROUND_EN; sum mode res=-5 sign-extended to 10 bits (0x3FB).
REQ-034 in_val held 1 for 8 cycles with alternating mode and ramp data -> 8 consecutive out_val cycles, each res/out_mode matching the reference model.
REQ-035 Issue 2 inputs, assert flush in cycle 2 together with a third input -> only the third result appears, 3 cycles after acceptance.
REQ-036 Drop rst_n for one cycle with 2 results in flight -> out_val=0 and res=0 immediately; no stale results afterward. N=1 and N=6 builds pass REQ-031 scaled to their input counts.
